panel_inputs: RTL and testbench

//  Front-panel input reader: the input-side counterpart of the board LED/7-seg status outputs.
//  - Samples DE-board pushbuttons (active-low) and slide switches.
//  - Synchronises and debounces them.
//  - Delivers clean levels plus one-cycle press/release/change events to the control block
//    and OSD logic.

---
 rtl/panel_pkg.sv | 23 ++
 rtl/debounce_cell.sv | 48 ++++
 rtl/panel_inputs.sv | 146 ++++++++++++++
 tb/tb_panel_inputs.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
// Shared constants for the front-panel input reader: input counts, key indices
// and the counter-width helper used by the prescaler and debounce counters.
package panel_pkg;

    localparam int NUM_KEYS   = 4;
    localparam int NUM_SW     = 10;
    localparam int NUM_INPUTS = NUM_KEYS + NUM_SW;
    localparam int SW_BASE    = NUM_KEYS;

    localparam int KEY0 = 0;
    localparam int KEY1 = 1;
    localparam int KEY2 = 2;
    localparam int KEY3 = 3;

    // Number of bits needed to hold the values 0..value-1 (never less than 1).
    function automatic int clog2(input int value);
        int w;
        for (w = 1; (1 << w) < value; w++) begin
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One debounced input: a stable level that follows din only after din has differed
// from it for DEB_TICKS consecutive ticks, with registered edge events.
module debounce_cell
    import panel_pkg::*;
#(
    parameter int DEB_TICKS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic din,
    input  logic en_evt,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CW = clog2(DEB_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_TICKS - 1);

    logic [CW-1:0] count;

    // Any clock where din agrees with the stable level restarts the qualification.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 1'b0;
            count  <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (din == stable) begin
                count <= '0;
            end else if (tick) begin
                if (count == LAST) begin
                    stable <= din;
                    count  <= '0;
                    rise   <= en_evt & din;
                    fall   <= en_evt & ~din;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/panel_inputs.sv
// Front-panel reader: synchronises and debounces DE-board keys and switches.
// Define PANEL_AUTOREPEAT_EN to add per-key auto-repeat press pulses.
module panel_inputs
    import panel_pkg::*;
#(
    parameter int TICK_DIV  = 28000,
    parameter int DEB_TICKS = 8,
    parameter int REP_DELAY = 500,
    parameter int REP_RATE  = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [NUM_SW-1:0]   sw,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_SW-1:0]   sw_state,
    output logic [NUM_SW-1:0]   sw_change,
    output logic                ready
);

    if (TICK_DIV < 2 || DEB_TICKS < 1 || REP_DELAY < 1 || REP_RATE < 1) begin : g_param_check
        $error("panel_inputs: parameter out of range");
    end

    localparam int PW = clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam int SCW = clog2(DEB_TICKS + 2);
    localparam logic [SCW-1:0] SETTLE_DONE = SCW'(DEB_TICKS + 1);

    logic [NUM_KEYS-1:0]   key_meta, key_sync;
    logic [NUM_SW-1:0]     sw_meta, sw_sync;
    logic [PW-1:0]         presc;
    logic                  tick;
    logic [SCW-1:0]        settle_cnt;
    logic [NUM_INPUTS-1:0] din_all, stable_all, rise_all, fall_all;
    logic [NUM_KEYS-1:0]   rep_pulse;

    // Key synchronisers reset to "released" so no phantom press is seen after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta <= '1;
            key_sync <= '1;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            key_meta <= key_n;
            key_sync <= key_meta;
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            tick  <= 1'b1;
        end else begin
            presc <= presc + 1'b1;
            tick  <= 1'b0;
        end
    end

    // Events stay masked until every input has had a full debounce window to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
            ready      <= 1'b0;
        end else begin
            if (tick && settle_cnt != SETTLE_DONE) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            if (settle_cnt == SETTLE_DONE) begin
                ready <= 1'b1;
            end
        end
    end

    assign din_all = {sw_sync, ~key_sync};

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_cell
        debounce_cell #(
            .DEB_TICKS(DEB_TICKS)
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .din   (din_all[i]),
            .en_evt(ready),
            .stable(stable_all[i]),
            .rise  (rise_all[i]),
            .fall  (fall_all[i])
        );
    end

`ifdef PANEL_AUTOREPEAT_EN
    localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int RW = clog2(REP_MAX + 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REP_RATE - 1);

    logic [RW-1:0]       rep_cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] rep_phase;

    // A repeat is suppressed once the synchronised key is up, so it can never
    // coincide with the release event of the same key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                rep_cnt[k] <= '0;
            end
            rep_phase <= '0;
            rep_pulse <= '0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                rep_pulse[k] <= 1'b0;
                if (!stable_all[k]) begin
                    rep_cnt[k]   <= '0;
                    rep_phase[k] <= 1'b0;
                end else if (tick) begin
                    if (rep_cnt[k] == (rep_phase[k] ? RATE_LAST : DELAY_LAST)) begin
                        rep_cnt[k]   <= '0;
                        rep_phase[k] <= 1'b1;
                        rep_pulse[k] <= ready & din_all[k];
                    end else begin
                        rep_cnt[k] <= rep_cnt[k] + 1'b1;
                    end
                end
            end
        end
    end
`else
    assign rep_pulse = '0;
`endif

    assign key_state   = {stable_all[KEY3], stable_all[KEY2], stable_all[KEY1], stable_all[KEY0]};
    assign key_press   = rise_all[KEY3:KEY0] | rep_pulse;
    assign key_release = fall_all[KEY3:KEY0];
    assign sw_state    = stable_all[NUM_INPUTS-1:SW_BASE];
    assign sw_change   = rise_all[NUM_INPUTS-1:SW_BASE] | fall_all[NUM_INPUTS-1:SW_BASE];

endmodule

// File: tb/tb_panel_inputs.sv
// Directed self-checking bench for panel_inputs (TICK_DIV=4, DEB_TICKS=3).
// Expected repeat timing follows PANEL_AUTOREPEAT_EN when it is defined for the build.
module tb_panel_inputs;

    localparam int TICK_DIV  = 4;
    localparam int DEB_TICKS = 3;
    localparam int REP_DELAY = 5;
    localparam int REP_RATE  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_n;
    logic [9:0] sw;
    logic [3:0] key_state, key_press, key_release;
    logic [9:0] sw_state, sw_change;
    logic       ready;

    int checks   = 0;
    int failures = 0;
    int press_cnt   [4];
    int release_cnt [4];
    int change_cnt  [10];

    panel_inputs #(
        .TICK_DIV (TICK_DIV),
        .DEB_TICKS(DEB_TICKS),
        .REP_DELAY(REP_DELAY),
        .REP_RATE (REP_RATE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .sw         (sw),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .sw_state   (sw_state),
        .sw_change  (sw_change),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled half a period after the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (key_press[i] === 1'b1) press_cnt[i]++;
            if (key_release[i] === 1'b1) release_cnt[i]++;
        end
        for (int i = 0; i < 10; i++) begin
            if (sw_change[i] === 1'b1) change_cnt[i]++;
        end
    end

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_counts;
        for (int i = 0; i < 4; i++) begin
            press_cnt[i]   = 0;
            release_cnt[i] = 0;
        end
        for (int i = 0; i < 10; i++) change_cnt[i] = 0;
    endtask

    task automatic test_reset;
        int cycles;
        int total;
        logic found;
        rst   = 1'b1;
        key_n = 4'hF;
        sw    = 10'h201;
        repeat (3) step;
        checks++;
        if ({key_state, key_press, key_release, sw_state, sw_change, ready} !== 33'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %h, expected 0",
                     {key_state, key_press, key_release, sw_state, sw_change, ready});
        end
        clear_counts();
        rst    = 1'b0;
        cycles = 0;
        found  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step;
            cycles++;
            if (ready === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || cycles < 16 || cycles > 20) begin
            failures++;
            $display("[TB] FAIL ready_time: got found=%0b cycles=%0d, expected 16..20", found, cycles);
        end
        checks++;
        if (sw_state !== 10'h201) begin
            failures++;
            $display("[TB] FAIL init_sw_state: got %h, expected 201", sw_state);
        end
        total = 0;
        for (int i = 0; i < 10; i++) total += change_cnt[i];
        checks++;
        if (total != 0) begin
            failures++;
            $display("[TB] FAIL init_sw_change: got %0d pulses, expected 0", total);
        end
        checks++;
        if (key_state !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL init_key_state: got %b, expected 0000", key_state);
        end
    endtask

    task automatic test_key_hold;
        int cycles;
        int others;
        logic found;
        clear_counts();
        key_n  = 4'b1011;
        cycles = 0;
        found  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step;
            cycles++;
            if (key_state[2] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || cycles > 18) begin
            failures++;
            $display("[TB] FAIL key2_accept_time: got found=%0b cycles=%0d, expected <=18", found, cycles);
        end
        checks++;
        if (key_press !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL key2_press_aligned: got %b, expected 0100", key_press);
        end
        repeat (12) step;
        checks++;
        if (key_state !== 4'b0100 || sw_state !== 10'h201) begin
            failures++;
            $display("[TB] FAIL key2_hold_state: got key=%b sw=%h, expected key=0100 sw=201",
                     key_state, sw_state);
        end
        others = press_cnt[0] + press_cnt[1] + press_cnt[3];
        for (int i = 0; i < 4; i++) others += release_cnt[i];
        for (int i = 0; i < 10; i++) others += change_cnt[i];
        checks++;
        if (press_cnt[2] != 1 || others != 0) begin
            failures++;
            $display("[TB] FAIL key2_pulses: got press2=%0d others=%0d, expected 1 and 0",
                     press_cnt[2], others);
        end
        key_n = 4'hF;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step;
            if (key_state[2] === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || key_release !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL key2_release: got found=%0b release=%b, expected 1 and 0100",
                     found, key_release);
        end
        repeat (4) step;
    endtask

    task automatic test_bounce;
        clear_counts();
        key_n = 4'b1110;
        repeat (8) step;
        key_n = 4'b1111;
        repeat (4) step;
        key_n = 4'b1110;
        repeat (8) step;
        key_n = 4'b1111;
        repeat (24) step;
        checks++;
        if (press_cnt[0] != 0 || release_cnt[0] != 0) begin
            failures++;
            $display("[TB] FAIL bounce_events: got press=%0d release=%0d, expected 0 and 0",
                     press_cnt[0], release_cnt[0]);
        end
        checks++;
        if (key_state !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL bounce_state: got %b, expected 0000", key_state);
        end
    endtask

    task automatic test_simultaneous;
        logic found;
        clear_counts();
        sw    = 10'h221;
        key_n = 4'b1101;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step;
            if (sw_change[5] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || key_press !== 4'b0010 || sw_change !== 10'h020) begin
            failures++;
            $display("[TB] FAIL simul_pulse: got found=%0b press=%b change=%h, expected 1 0010 020",
                     found, key_press, sw_change);
        end
        checks++;
        if (sw_state !== 10'h221 || key_state !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL simul_state: got sw=%h key=%b, expected 221 0010", sw_state, key_state);
        end
        key_n = 4'hF;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step;
            if (key_release[1] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        repeat (12) step;
        checks++;
        if (!found || release_cnt[1] != 1 || press_cnt[1] != 1 || change_cnt[5] != 1) begin
            failures++;
            $display("[TB] FAIL simul_counts: got found=%0b rel1=%0d press1=%0d chg5=%0d, expected 1 1 1 1",
                     found, release_cnt[1], press_cnt[1], change_cnt[5]);
        end
        checks++;
        if (key_state !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL simul_released: got %b, expected 0000", key_state);
        end
    endtask

    task automatic test_reset_mid;
        int total;
        logic found;
        clear_counts();
        key_n = 4'b0111;
        repeat (10) step;
        checks++;
        if (key_state !== 4'b0000 || sw_state !== 10'h221) begin
            failures++;
            $display("[TB] FAIL pre_reset_state: got key=%b sw=%h, expected 0000 221", key_state, sw_state);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({key_state, key_press, key_release, sw_state, sw_change, ready} !== 33'd0) begin
            failures++;
            $display("[TB] FAIL async_reset_outputs: got %h, expected 0",
                     {key_state, key_press, key_release, sw_state, sw_change, ready});
        end
        repeat (3) step;
        clear_counts();
        rst   = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step;
            if (ready === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || key_state !== 4'b1000 || sw_state !== 10'h221) begin
            failures++;
            $display("[TB] FAIL held_key_init: got found=%0b key=%b sw=%h, expected 1 1000 221",
                     found, key_state, sw_state);
        end
        total = 0;
        for (int i = 0; i < 4; i++) total += press_cnt[i] + release_cnt[i];
        for (int i = 0; i < 10; i++) total += change_cnt[i];
        checks++;
        if (total != 0) begin
            failures++;
            $display("[TB] FAIL init_events_masked: got %0d pulses, expected 0", total);
        end
        key_n = 4'hF;
        repeat (24) step;
    endtask

    task automatic test_autorepeat;
        int offsets[$];
        int expected[$];
        int off;
        logic found;
`ifdef PANEL_AUTOREPEAT_EN
        expected = '{0, 20, 28, 36, 44};
`else
        expected = '{0};
`endif
        clear_counts();
        key_n = 4'b1110;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step;
            if (key_state[0] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("[TB] FAIL rep_accept: got no accept within 40 clk, expected accept");
        end
        off = 0;
        for (int i = 0; i <= 72; i++) begin
            if (i == 48) key_n = 4'hF;
            if (key_press[0] === 1'b1) offsets.push_back(off);
            step;
            off++;
        end
        checks++;
        if (offsets.size() != expected.size()) begin
            failures++;
            $display("[TB] FAIL rep_count: got %0d pulses, expected %0d", offsets.size(), expected.size());
        end
        for (int i = 0; i < expected.size(); i++) begin
            checks++;
            if (i >= offsets.size() || offsets[i] != expected[i]) begin
                failures++;
                $display("[TB] FAIL rep_offset[%0d]: got %0d, expected %0d", i,
                         (i < offsets.size()) ? offsets[i] : -1, expected[i]);
            end
        end
        checks++;
        if (key_state[0] !== 1'b0 || release_cnt[0] != 1) begin
            failures++;
            $display("[TB] FAIL rep_release: got state=%b releases=%0d, expected 0 and 1",
                     key_state[0], release_cnt[0]);
        end
    endtask

    initial begin
        test_reset();
        test_key_hold();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_autorepeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
